// File: rtl/space_key_conditioner.sv
`default_nettype none
// ============================================================================
// space_key_conditioner: one frame-aligned pulse per space press, with lockout
// Revision: 1.0
// ============================================================================
module space_key_conditioner #(
  parameter int         LOCKOUT_FRAMES = 4,
  parameter int         CNT_W          = 3,
  parameter logic [1:0] PLAYING        = 2'b00
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_hold,
  input  logic       sync,
  input  logic [1:0] game_status,
  output logic       key_pulse,
  output logic       restart_pulse,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARMED        = 3'd1,
    S_FIRE         = 3'd2,
    S_LOCKOUT      = 3'd3,
    S_WAIT_RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_lock_load = CNT_W'(LOCKOUT_FRAMES);
  localparam logic [CNT_W-1:0] c_lock_one  = CNT_W'(1);
  localparam bit               c_lock_en   = (LOCKOUT_FRAMES > 0);
  localparam logic [7:0]       c_cnt_max   = 8'hFF;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_key_q;
  logic             r_key_q_d;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_lock_cnt_nxt;
  logic             r_fire_kind;
  logic             w_fire_kind_nxt;
  logic             r_key_pulse;
  logic             r_restart_pulse;
  logic             r_busy;
  logic [7:0]       r_press_count;

  logic w_rise;
  logic w_not_playing;
  logic w_fire;
  logic w_after_lock;

  assign w_rise        = r_key_q & ~r_key_q_d;
  assign w_not_playing = (game_status != PLAYING);
  assign w_fire        = (r_state == S_ARMED) & sync;
  // A key still held when the press is retired must be released before re-arming.
  assign w_after_lock  = r_key_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_q   <= 1'b0;
      r_key_q_d <= 1'b0;
    end else begin
      r_key_q   <= key_hold;
      r_key_q_d <= r_key_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_lock_cnt  <= '0;
      r_fire_kind <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_fire_kind <= w_fire_kind_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lock_cnt_nxt  = r_lock_cnt;
    w_fire_kind_nxt = r_fire_kind;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt     = S_ARMED;
          w_fire_kind_nxt = w_not_playing;
        end
      end
      S_ARMED: begin
        // Kind is re-evaluated at fire time so a status change while armed is honoured.
        if (sync) begin
          w_state_nxt     = S_FIRE;
          w_fire_kind_nxt = w_not_playing;
        end
      end
      S_FIRE: begin
        if (c_lock_en) begin
          w_lock_cnt_nxt = c_lock_load;
          w_state_nxt    = S_LOCKOUT;
        end else begin
          w_state_nxt = w_after_lock ? S_WAIT_RELEASE : S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (r_lock_cnt == '0) begin
          w_state_nxt = w_after_lock ? S_WAIT_RELEASE : S_IDLE;
        end else if (sync) begin
          w_lock_cnt_nxt = r_lock_cnt - c_lock_one;
          if (r_lock_cnt == c_lock_one) begin
            w_state_nxt = w_after_lock ? S_WAIT_RELEASE : S_IDLE;
          end
        end
      end
      S_WAIT_RELEASE: begin
        if (!r_key_q) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes and counter are registered on the edge entering FIRE so they are high during FIRE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_pulse     <= 1'b0;
      r_restart_pulse <= 1'b0;
      r_busy          <= 1'b0;
      r_press_count   <= 8'd0;
    end else begin
      r_key_pulse     <= w_fire & ~w_fire_kind_nxt;
      r_restart_pulse <= w_fire & w_fire_kind_nxt;
      r_busy          <= (w_state_nxt != S_IDLE);
      if (w_fire && (r_press_count != c_cnt_max)) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  assign key_pulse     = r_key_pulse;
  assign restart_pulse = r_restart_pulse;
  assign busy          = r_busy;
  assign press_count   = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_space_key_conditioner.sv
`default_nettype none
// ============================================================================
// tb_space_key_conditioner: directed + random stimulus against a press-level model
// Revision: 1.0
// ============================================================================
module tb_space_key_conditioner;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_hold = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] game_status = 2'b00;
  logic       key_pulse;
  logic       restart_pulse;
  logic       busy;
  logic [7:0] press_count;

  int checks = 0;
  int failures = 0;
  int kp_seen = 0;
  int rp_seen = 0;
  int frame_len = 20;
  int frame_pos = 0;

  always #5 clk = ~clk;

  space_key_conditioner #(
    .LOCKOUT_FRAMES(LOCK),
    .CNT_W(3),
    .PLAYING(2'b00)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .key_hold(key_hold),
    .sync(sync),
    .game_status(game_status),
    .key_pulse(key_pulse),
    .restart_pulse(restart_pulse),
    .busy(busy),
    .press_count(press_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Press-level model: flags describe where the current press is in its life.
  bit m_kq, m_kqd, m_armed, m_fire, m_wait, m_kp, m_rp, m_rise;
  int m_lock, m_cnt;

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_kq = 0; m_kqd = 0; m_armed = 0; m_fire = 0; m_wait = 0;
      m_kp = 0; m_rp = 0; m_lock = 0; m_cnt = 0;
    end else begin
      m_rise = m_kq && !m_kqd;
      m_kp = 0;
      m_rp = 0;
      if (m_fire) begin
        m_fire = 0;
        if (LOCK > 0) m_lock = LOCK;
        else m_wait = m_kq;
      end else if (m_lock > 0) begin
        if (sync) begin
          m_lock--;
          if (m_lock == 0) m_wait = m_kq;
        end
      end else if (m_wait) begin
        if (!m_kq) m_wait = 0;
      end else if (m_armed) begin
        if (sync) begin
          m_armed = 0;
          m_fire = 1;
          if (game_status != 2'b00) m_rp = 1;
          else m_kp = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (m_rise) begin
        m_armed = 1;
      end
      m_kqd = m_kq;
      m_kq = key_hold;
    end
    #2;
    chk("key_pulse", key_pulse, int'(m_kp));
    chk("restart_pulse", restart_pulse, int'(m_rp));
    chk("busy", busy, int'(m_armed | m_fire | (m_lock > 0) | m_wait));
    chk("press_count", press_count, m_cnt);
    chk("exclusive", int'(key_pulse & restart_pulse), 0);
    kp_seen += int'(key_pulse);
    rp_seen += int'(restart_pulse);
  end

  task automatic tick(input bit kh, input bit sy);
    @(negedge clk);
    key_hold = kh;
    sync = sy;
  endtask

  task automatic step(input bit kh);
    frame_pos = (frame_pos + 1) % frame_len;
    tick(kh, frame_pos == 0);
  endtask

  task automatic run(input int n, input bit kh);
    repeat (n) step(kh);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    step(0);
    step(0);
    while (busy && n < budget) begin
      step(0);
      n++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  int k0, r0;
  bit rkh, rsy;

  initial begin
    // Reset held with key down and sync toggling.
    resetn = 1'b0;
    for (int i = 0; i < 6; i++) tick(1, i[0]);
    chk("rst_busy", busy, 0);
    chk("rst_count", press_count, 0);
    chk("rst_key_pulse", key_pulse, 0);
    resetn = 1'b1;
    frame_len = 20;
    frame_pos = 0;
    run(30, 1);
    chk("held_at_reset_fires", press_count, 1);
    run(5, 0);
    wait_idle(200);

    // Single press; the sync coincident with the rise must not be used.
    k0 = kp_seen; r0 = rp_seen;
    tick(1, 0);
    tick(1, 1);
    tick(1, 0);
    chk("armed_busy", busy, 1);
    repeat (17) tick(1, 0);
    tick(1, 1);
    chk("pre_fire_key_pulse", key_pulse, 0);
    tick(1, 0);
    chk("fire_key_pulse", key_pulse, 1);
    chk("fire_restart_pulse", restart_pulse, 0);
    chk("fire_count", press_count, 2);
    frame_pos = 1;
    run(3, 1);
    run(100, 0);
    wait_idle(200);
    chk("single_press_pulses", kp_seen - k0, 1);
    chk("single_press_restarts", rp_seen - r0, 0);

    // Taps inside the lockout window are discarded.
    k0 = kp_seen;
    run(3, 1); run(12, 0); run(3, 1); run(17, 0); run(3, 1); run(70, 0);
    wait_idle(300);
    chk("lockout_one_pulse", kp_seen - k0, 1);
    run(3, 1); run(5, 0);
    wait_idle(300);
    chk("after_lockout_refire", kp_seen - k0, 2);
    chk("after_lockout_count", press_count, 4);

    // Held for ten frames: one pulse, then release needed.
    k0 = kp_seen;
    run(200, 1);
    chk("held_one_pulse", kp_seen - k0, 1);
    chk("held_wait_release", busy, 1);
    step(0);
    step(0);
    chk("release_busy_still", busy, 1);
    step(0);
    chk("release_idle", busy, 0);

    // Game over press goes to restart.
    game_status = 2'b10;
    k0 = kp_seen; r0 = rp_seen;
    run(3, 1); run(30, 0);
    wait_idle(300);
    chk("gameover_restart", rp_seen - r0, 1);
    chk("gameover_no_key", kp_seen - k0, 0);

    // Status changes to game over while armed.
    game_status = 2'b00;
    frame_pos = 0;
    run(2, 1);
    game_status = 2'b10;
    run(30, 0);
    wait_idle(300);
    game_status = 2'b00;
    chk("relatch_restart", rp_seen - r0, 2);
    chk("relatch_no_key", kp_seen - k0, 0);
    chk("relatch_count", press_count, 7);

    // Saturation.
    frame_len = 6;
    frame_pos = 0;
    for (int i = 0; i < 260; i++) begin
      run(2, 1);
      wait_idle(100);
    end
    chk("saturated", press_count, 255);

    // Reset while armed discards the press.
    frame_len = 20;
    frame_pos = 0;
    run(3, 1);
    step(0);
    chk("armed_before_reset", busy, 1);
    resetn = 1'b0;
    run(3, 0);
    chk("midop_reset_count", press_count, 0);
    chk("midop_reset_busy", busy, 0);
    resetn = 1'b1;
    k0 = kp_seen; r0 = rp_seen;
    run(60, 0);
    chk("midop_no_key", kp_seen - k0, 0);
    chk("midop_no_restart", rp_seen - r0, 0);
    chk("midop_count_zero", press_count, 0);

    // Random traffic checked cycle by cycle against the model.
    rkh = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) rkh = ~rkh;
      rsy = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) game_status = 2'($urandom_range(0, 3));
      resetn = ($urandom_range(0, 999) != 0);
      tick(rkh, rsy);
    end
    resetn = 1'b1;
    run(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
